jk_bank_sched: RTL and testbench

Command scheduler for a shared bank of N JK flip-flops. Two requesters issue SET/CLEAR/TOGGLE/HOLD commands with per-bit masks. The block arbitrates between them round-robin and sequences the bank's `enabled`/`J`/`K` inputs for exactly one clock edge per command. It sits directly in front of the FF_JK instances and reads their `Q` vector back for optional verification.

---
 rtl/jk_bank_sched.sv | 160 ++++++++++++++++
 tb/tb_jk_bank_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sched.sv
// jk_bank_sched: round-robin command scheduler driving enabled/J/K of a shared JK flop bank.
// Define JK_READBACK_EN to add the CHECK state, q snapshot and sticky readback error flag.
module jk_bank_sched #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [1:0]   op0,
    input  logic [1:0]   op1,
    input  logic [N-1:0] mask0,
    input  logic [N-1:0] mask1,
    input  logic [N-1:0] q,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic         enabled,
    output logic [N-1:0] j,
    output logic [N-1:0] k,
    output logic         busy,
    output logic         err
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        DRIVE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t       state_reg, state_next;
    logic         ptr_reg, ptr_next;
    logic         win_reg, win_next;
    logic [1:0]   op_reg, op_next;
    logic [N-1:0] mask_reg, mask_next;
    logic         winner;
    logic [N-1:0] j_cmd, k_cmd;
    logic         gnt0_next, gnt1_next, done0_next, done1_next, enabled_next, busy_next;
    logic [N-1:0] j_next, k_next;

    // The pointer side wins a tie; a lone request is always served.
    assign winner = (req0 && req1) ? ptr_reg : req1;

    // op encoding maps straight onto J (bit 0) and K (bit 1) for selected bits.
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
        assign j_cmd[gi] = mask_reg[gi] & op_reg[0];
        assign k_cmd[gi] = mask_reg[gi] & op_reg[1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
            win_reg   <= 1'b0;
            op_reg    <= 2'b00;
            mask_reg  <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            enabled   <= 1'b0;
            j         <= '0;
            k         <= '0;
            busy      <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            win_reg   <= win_next;
            op_reg    <= op_next;
            mask_reg  <= mask_next;
            gnt0      <= gnt0_next;
            gnt1      <= gnt1_next;
            done0     <= done0_next;
            done1     <= done1_next;
            enabled   <= enabled_next;
            j         <= j_next;
            k         <= k_next;
            busy      <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        win_next   = win_reg;
        op_next    = op_reg;
        mask_next  = mask_reg;
        unique case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    state_next = GRANT;
                    win_next   = winner;
                    ptr_next   = ~winner;
                    op_next    = winner ? op1 : op0;
                    mask_next  = winner ? mask1 : mask0;
                end
            end
            GRANT: state_next = DRIVE;
`ifdef JK_READBACK_EN
            DRIVE: state_next = CHECK;
`else
            DRIVE: state_next = DONE;
`endif
            CHECK: state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in that state.
    always_comb begin
        gnt0_next    = (state_next == GRANT) && !win_next;
        gnt1_next    = (state_next == GRANT) &&  win_next;
        done0_next   = (state_next == DONE)  && !win_next;
        done1_next   = (state_next == DONE)  &&  win_next;
        enabled_next = (state_next == DRIVE);
        j_next       = enabled_next ? j_cmd : '0;
        k_next       = enabled_next ? k_cmd : '0;
        busy_next    = (state_next != IDLE);
    end

`ifdef JK_READBACK_EN
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    logic [N-1:0] snap_reg, snap_next, expected;
    logic         err_next;

    always_comb begin
        snap_next = ((state_reg == IDLE) && (state_next == GRANT)) ? q : snap_reg;
        expected  = snap_reg;
        case (op_reg)
            OP_SET:    expected = snap_reg | mask_reg;
            OP_CLEAR:  expected = snap_reg & ~mask_reg;
            OP_TOGGLE: expected = snap_reg ^ mask_reg;
            default:   expected = snap_reg;
        endcase
        // q already reflects the DRIVE edge when we are in CHECK.
        err_next = err | ((state_reg == CHECK) && (|(q ^ expected)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_reg <= '0;
            err      <= 1'b0;
        end else begin
            snap_reg <= snap_next;
            err      <= err_next;
        end
    end
`else
    logic unused_q;
    assign unused_q = ^q;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_jk_bank_sched.sv
// Directed bench for jk_bank_sched with a behavioural JK bank (and stuck-at-0 injection) on q.
module tb_jk_bank_sched;
    localparam int N = 4;
`ifdef JK_READBACK_EN
    localparam int DONE_LAT = 4;
`else
    localparam int DONE_LAT = 3;
`endif
    localparam logic [1:0] HOLD = 2'b00, SET = 2'b01, CLEAR = 2'b10, TOGGLE = 2'b11;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [1:0] op0 = 2'b00, op1 = 2'b00;
    logic [N-1:0] mask0 = '0, mask1 = '0;
    logic gnt0, gnt1, done0, done1, enabled, busy, err;
    logic [N-1:0] j, k;

    logic [N-1:0] bank_q = '0;
    logic [N-1:0] stuck0 = '0;
    logic         load_en = 1'b0;
    logic [N-1:0] load_val = '0;
    logic [N-1:0] q_bus;

    int checks = 0;
    int errors = 0;

    assign q_bus = bank_q & ~stuck0;

    always #5 clk = ~clk;

    // Behavioural JK bank: loads for setup, otherwise follows J/K while enabled.
    always @(posedge clk) begin
        if (load_en) bank_q <= load_val;
        else if (enabled === 1'b1) begin
            for (int i = 0; i < N; i++) begin
                case ({j[i], k[i]})
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: bank_q[i] <= bank_q[i];
                endcase
            end
        end
    end

    jk_bank_sched #(.N(N)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .mask0(mask0), .mask1(mask1), .q(q_bus),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .enabled(enabled), .j(j), .k(k), .busy(busy), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bank(input logic [N-1:0] v);
        load_en = 1'b1;
        load_val = v;
        tick();
        load_en = 1'b0;
    endtask

    // Issues one command from one requester and records when each event was seen.
    task automatic run_cmd(input bit who, input logic [1:0] op, input logic [N-1:0] m,
                           output int gnt_at, output int en_at, output int done_at,
                           output logic [N-1:0] j_at, output logic [N-1:0] k_at);
        gnt_at = -1; en_at = -1; done_at = -1; j_at = 'x; k_at = 'x;
        if (who) begin req1 = 1'b1; op1 = op; mask1 = m; end
        else     begin req0 = 1'b1; op0 = op; mask0 = m; end
        for (int c = 1; c <= 20 && done_at < 0; c++) begin
            tick();
            if ((who ? gnt1 : gnt0) === 1'b1) gnt_at = c;
            if (enabled === 1'b1) begin en_at = c; j_at = j; k_at = k; end
            if ((who ? done1 : done0) === 1'b1) done_at = c;
        end
        if (who) req1 = 1'b0; else req0 = 1'b0;
        tick();
        $display("txn req%0d op=%b mask=%b gnt@%0d en@%0d done@%0d q=%b err=%b",
                 who, op, m, gnt_at, en_at, done_at, q_bus, err);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL reset_enabled: got %b want 0", enabled); end
        checks++; if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {gnt0, gnt1, done0, done1}); end
        checks++; if ({j, k} !== 8'h00) begin errors++; $display("FAIL reset_jk: got %b want 00000000", {j, k}); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_set_latency();
        load_bank(4'b0000);
        req0 = 1'b1; op0 = SET; mask0 = 4'b0011;
        tick();
        checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL set_gnt: got gnt0=%b gnt1=%b want 1/0", gnt0, gnt1); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL set_busy_rise: got %b want 1", busy); end
        tick();
        checks++; if (enabled !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL set_drive: got en=%b gnt0=%b want 1/0", enabled, gnt0); end
        checks++; if (j !== 4'b0011 || k !== 4'b0000) begin errors++; $display("FAIL set_jk: got j=%b k=%b want 0011/0000", j, k); end
        tick();
        checks++; if (q_bus !== 4'b0011) begin errors++; $display("FAIL set_q: got %b want 0011", q_bus); end
        checks++; if (enabled !== 1'b0) begin errors++; $display("FAIL set_en_drop: got %b want 0", enabled); end
`ifdef JK_READBACK_EN
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL set_done_early: got %b want 0", done0); end
        tick();
`endif
        checks++; if (done0 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL set_done: got done0=%b done1=%b want 1/0", done0, done1); end
        req0 = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL set_idle: got busy=%b done0=%b want 0/0", busy, done0); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL set_err: got %b want 0", err); end
        $display("txn req0 op=01 mask=0011 q=%b err=%b", q_bus, err);
    endtask

    task automatic test_reset_mid_drive();
        bit saw_done;
        load_bank(4'b1010);
        req0 = 1'b1; op0 = SET; mask0 = 4'b0101;
        tick();
        tick();
        checks++; if (enabled !== 1'b1) begin errors++; $display("FAIL abort_in_drive: got en=%b want 1", enabled); end
        #2 reset = 1'b0;
        #1;
        checks++; if (enabled !== 1'b0 || busy !== 1'b0 || j !== 4'b0000) begin errors++; $display("FAIL abort_async: got en=%b busy=%b j=%b want 0/0/0000", enabled, busy, j); end
        req0 = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done0 === 1'b1 || done1 === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got activity=%b want 0", saw_done); end
        checks++; if (q_bus !== 4'b1010) begin errors++; $display("FAIL abort_q: got %b want 1010", q_bus); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err: got %b want 0", err); end
        $display("txn aborted req0 op=01 mask=0101 q=%b", q_bus);
    endtask

    task automatic test_both_requests();
        int order[2];
        logic [N-1:0] q_after[2];
        int ng = 0, nd = 0;
        order[0] = -1; order[1] = -1; q_after[0] = 'x; q_after[1] = 'x;
        load_bank(4'b0011);
        req0 = 1'b1; op0 = TOGGLE; mask0 = 4'b1111;
        req1 = 1'b1; op1 = CLEAR;  mask1 = 4'b0100;
        for (int c = 0; c < 40 && nd < 2; c++) begin
            tick();
            if (gnt0 === 1'b1 && ng < 2) begin order[ng] = 0; ng++; end
            if (gnt1 === 1'b1 && ng < 2) begin order[ng] = 1; ng++; end
            if (done0 === 1'b1) begin q_after[nd] = q_bus; nd++; req0 = 1'b0; end
            if (done1 === 1'b1) begin q_after[nd] = q_bus; nd++; req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        checks++; if (nd !== 2) begin errors++; $display("FAIL both_dones: got %0d want 2", nd); end
        checks++; if (order[0] !== 0 || order[1] !== 1) begin errors++; $display("FAIL both_order: got %0d,%0d want 0,1", order[0], order[1]); end
        checks++; if (q_after[0] !== 4'b1100) begin errors++; $display("FAIL both_q_first: got %b want 1100", q_after[0]); end
        checks++; if (q_after[1] !== 4'b1000) begin errors++; $display("FAIL both_q_second: got %b want 1000", q_after[1]); end
        $display("txn pair grants=%0d,%0d q=%b", order[0], order[1], q_bus);
    endtask

    task automatic test_alternate();
        int g[4];
        int ng = 0;
        bit idle = 1'b0;
        for (int i = 0; i < 4; i++) g[i] = -1;
        req0 = 1'b1; op0 = HOLD; mask0 = 4'b0000;
        req1 = 1'b1; op1 = HOLD; mask1 = 4'b0000;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            tick();
            if (gnt0 === 1'b1) begin g[ng] = 0; ng++; end
            else if (gnt1 === 1'b1) begin g[ng] = 1; ng++; end
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int c = 0; c < 10 && !idle; c++) begin
            tick();
            if (busy === 1'b0) idle = 1'b1;
        end
        checks++; if (ng !== 4) begin errors++; $display("FAIL alt_count: got %0d want 4", ng); end
        checks++; if (g[0] !== 0 || g[1] !== 1 || g[2] !== 0 || g[3] !== 1) begin errors++; $display("FAIL alt_order: got %0d%0d%0d%0d want 0101", g[0], g[1], g[2], g[3]); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL alt_idle: got busy=%b want 0", busy); end
        checks++; if (q_bus !== 4'b1000) begin errors++; $display("FAIL alt_q: got %b want 1000", q_bus); end
        $display("txn alternating grants=%0d%0d%0d%0d", g[0], g[1], g[2], g[3]);
    endtask

    task automatic test_null_ops();
        int ga, ea, da;
        logic [N-1:0] ja, ka;
        run_cmd(1'b0, HOLD, 4'b1111, ga, ea, da, ja, ka);
        checks++; if (ga !== 1 || ea !== 2) begin errors++; $display("FAIL hold_timing: got gnt@%0d en@%0d want 1/2", ga, ea); end
        checks++; if (ja !== 4'b0000 || ka !== 4'b0000) begin errors++; $display("FAIL hold_jk: got j=%b k=%b want 0000/0000", ja, ka); end
        checks++; if (da !== DONE_LAT) begin errors++; $display("FAIL hold_done: got %0d want %0d", da, DONE_LAT); end
        checks++; if (q_bus !== 4'b1000 || err !== 1'b0) begin errors++; $display("FAIL hold_q_err: got q=%b err=%b want 1000/0", q_bus, err); end
        run_cmd(1'b1, SET, 4'b0000, ga, ea, da, ja, ka);
        checks++; if (ga !== 1 || ea !== 2) begin errors++; $display("FAIL mask0_timing: got gnt@%0d en@%0d want 1/2", ga, ea); end
        checks++; if (ja !== 4'b0000 || ka !== 4'b0000) begin errors++; $display("FAIL mask0_jk: got j=%b k=%b want 0000/0000", ja, ka); end
        checks++; if (da !== DONE_LAT) begin errors++; $display("FAIL mask0_done: got %0d want %0d", da, DONE_LAT); end
        checks++; if (q_bus !== 4'b1000 || err !== 1'b0) begin errors++; $display("FAIL mask0_q_err: got q=%b err=%b want 1000/0", q_bus, err); end
    endtask

`ifdef JK_READBACK_EN
    task automatic test_readback_err();
        int ga, ea, da;
        logic [N-1:0] ja, ka;
        stuck0 = 4'b0001;
        load_bank(4'b0000);
        run_cmd(1'b0, SET, 4'b0001, ga, ea, da, ja, ka);
        checks++; if (da !== 4) begin errors++; $display("FAIL stuck_done: got %0d want 4", da); end
        checks++; if (q_bus !== 4'b0000) begin errors++; $display("FAIL stuck_q: got %b want 0000", q_bus); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL stuck_err: got %b want 1", err); end
        stuck0 = 4'b0000;
        run_cmd(1'b1, CLEAR, 4'b0001, ga, ea, da, ja, ka);
        checks++; if (q_bus !== 4'b0000 || err !== 1'b1) begin errors++; $display("FAIL sticky_err: got q=%b err=%b want 0000/1", q_bus, err); end
        reset = 1'b0;
        #2;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", err); end
        tick();
        reset = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_set_latency();
        test_reset_mid_drive();
        test_both_requests();
        test_alternate();
        test_null_ops();
`ifdef JK_READBACK_EN
        test_readback_err();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end within the time limit");
        $fatal(1, "watchdog");
    end
endmodule
